// File: rtl/project_spi_register_bridge.sv
// SPI mode-0 slave that turns 16-bit host frames into register-file write/read cycles.
// Define SPI_AUTOINC_EN for burst frames that continue with further data bytes at incrementing addresses.
module project_spi_register_bridge (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_write_en,
    output logic [5:0] o_address,
    output logic [7:0] o_data,
    input  logic [7:0] i_rdata,
    output logic       o_frame_err
);
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [2:0]        r_sclk_sync;
    logic [2:0]        r_cs_sync;
    logic [1:0]        r_mosi_sync;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_cs_rise;
    logic              w_cs_fall;
    logic              w_mosi;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_bit_cnt_next;
    // Only seven bits are stored; the eighth is the MOSI bit arriving with the completing edge.
    logic [DATA_W-2:0] r_shift_in;
    logic [DATA_W-2:0] w_shift_in_next;
    logic [DATA_W-1:0] w_shift_in_byte;
    logic [DATA_W-1:0] r_shift_out;
    logic [DATA_W-1:0] w_shift_out_next;
    logic              r_rw;
    logic              w_rw_next;
    logic              r_load_pend;
    logic              w_load_pend_next;
    logic              r_miso;
    logic              w_miso_next;
    logic              r_write_en;
    logic              w_write_en_next;
    logic [ADDR_W-1:0] r_address;
    logic [ADDR_W-1:0] w_address_next;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_next;
    logic              r_frame_err;
    logic              w_frame_err_next;
`ifdef SPI_AUTOINC_EN
    logic              r_inc_pend;
    logic              w_inc_pend_next;
    logic              r_byte_done;
    logic              w_byte_done_next;
`endif

    // Two-flop synchronisers; the third sclk/cs_n flop holds the previous value for edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[1:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_mosi      = r_mosi_sync[1];

    // Frame sequencer and datapath next-state logic.
    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_shift_in_next  = r_shift_in;
        w_shift_out_next = r_shift_out;
        w_rw_next        = r_rw;
        w_load_pend_next = r_load_pend;
        w_address_next   = r_address;
        w_data_next      = r_data;
        w_write_en_next  = 1'b0;
        w_frame_err_next = 1'b0;
        w_miso_next      = 1'b0;
        w_shift_in_byte  = {r_shift_in, w_mosi};
`ifdef SPI_AUTOINC_EN
        w_inc_pend_next  = 1'b0;
        w_byte_done_next = r_byte_done;
        // Advance after the strobe cycle so the write sees a stable address.
        if (r_inc_pend) begin
            w_address_next = r_address + ADDR_W'(1);
        end
`endif

        if (w_cs_rise) begin
            w_state_next = ST_IDLE;
`ifdef SPI_AUTOINC_EN
            if ((r_state == ST_CMD) ||
                ((r_state == ST_DATA) && ((r_bit_cnt[2:0] != 3'd0) || !r_byte_done))) begin
                w_frame_err_next = 1'b1;
            end
`else
            if ((r_state == ST_CMD) || (r_state == ST_DATA)) begin
                w_frame_err_next = 1'b1;
            end
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_next     = ST_CMD;
                        w_bit_cnt_next   = '0;
                        w_shift_in_next  = '0;
                        w_shift_out_next = '0;
                    end
                end
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        w_shift_in_next = w_shift_in_byte[DATA_W-2:0];
                        w_bit_cnt_next  = r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == CNT_W'(7)) begin
                            w_state_next     = ST_DATA;
                            w_rw_next        = w_shift_in_byte[7];
                            w_address_next   = w_shift_in_byte[ADDR_W-1:0];
                            w_load_pend_next = 1'b1;
`ifdef SPI_AUTOINC_EN
                            w_byte_done_next = 1'b0;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sclk_rise) begin
                        w_shift_in_next = w_shift_in_byte[DATA_W-2:0];
                        w_bit_cnt_next  = r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt[2:0] == 3'd7) begin
                            if (r_rw) begin
                                w_data_next     = w_shift_in_byte;
                                w_write_en_next = 1'b1;
                            end
`ifdef SPI_AUTOINC_EN
                            w_inc_pend_next  = 1'b1;
                            w_load_pend_next = 1'b1;
                            w_byte_done_next = 1'b1;
`else
                            w_state_next     = ST_HOLD;
`endif
                        end
                    end else if (w_sclk_fall) begin
                        if (r_load_pend) begin
                            w_shift_out_next = i_rdata;
                            w_load_pend_next = 1'b0;
                        end else begin
                            w_shift_out_next = {r_shift_out[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                // HOLD ignores every SCLK edge until cs_n rises.
                default: ;
            endcase
        end

        if (w_state_next == ST_DATA) begin
            w_miso_next = w_shift_out_next[DATA_W-1];
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_rw        <= 1'b0;
            r_load_pend <= 1'b0;
            r_miso      <= 1'b0;
            r_write_en  <= 1'b0;
            r_address   <= '0;
            r_data      <= '0;
            r_frame_err <= 1'b0;
`ifdef SPI_AUTOINC_EN
            r_inc_pend  <= 1'b0;
            r_byte_done <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift_in  <= w_shift_in_next;
            r_shift_out <= w_shift_out_next;
            r_rw        <= w_rw_next;
            r_load_pend <= w_load_pend_next;
            r_miso      <= w_miso_next;
            r_write_en  <= w_write_en_next;
            r_address   <= w_address_next;
            r_data      <= w_data_next;
            r_frame_err <= w_frame_err_next;
`ifdef SPI_AUTOINC_EN
            r_inc_pend  <= w_inc_pend_next;
            r_byte_done <= w_byte_done_next;
`endif
        end
    end

    assign o_miso      = r_miso;
    assign o_write_en  = r_write_en;
    assign o_address   = r_address;
    assign o_data      = r_data;
    assign o_frame_err = r_frame_err;

endmodule

// File: doc/project_spi_register_bridge.md
# project_spi_register_bridge

SPI slave front-end that turns serial host frames into the parallel register-file bus of the PWM peripheral: write strobe, 6-bit address, 8-bit write data, and 8-bit read-back. Sits directly upstream of the register file and its 64-register map. It replaces direct pin-level bus driving so that a microcontroller can configure all three PWM channels over four wires. All SPI pins are oversampled in the system clock domain.

## Interface
- No parameters. Frame format and widths are fixed.
- i_clk  in  1  system clock; all logic is on the rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to i_clk
- i_cs_n  in  1  SPI chip select, active low, asynchronous
- i_mosi  in  1  SPI data in, MSB first
- o_miso  out  1  SPI data out, MSB first
- o_write_en  out  1  one-cycle write strobe to the register file
- o_address  out  6  register address; held between frames
- o_data  out  8  write data; held between frames
- i_rdata  in  8  register-file read data for o_address; combinational, valid within the same cycle
- o_frame_err  out  1  one-cycle pulse on an aborted frame

## Operation
- Synchronisers: i_sclk, i_cs_n and i_mosi each pass through 2 flops. A third flop on sclk and cs_n provides edge detection. Only synchronised signals are used.
- Frame layout:
  - byte0 = {rw, 0, addr[5:0]}, where rw=1 means write.
  - byte1 = data.
  - A complete frame is 16 bits.
- MOSI is sampled on each detected SCLK rising edge into an 8-bit shift register. A 4-bit bit counter counts these edges.
- FSM states: IDLE, CMD, DATA, HOLD.
  - IDLE -> CMD on a detected cs_n falling edge. Counter and shift register are cleared.
  - CMD -> DATA on the 8th rising edge. The rw flag is latched and o_address <= shift[5:0].
  - DATA -> HOLD on the 16th rising edge. If rw=1: o_data <= byte1 and o_write_en pulses. If rw=0: nothing is written.
  - HOLD: further SCLK edges are ignored until cs_n rises, then the FSM goes to IDLE.
  - Any state -> IDLE on a cs_n rising edge. If this happens in CMD or DATA, the frame is aborted: no write, and o_frame_err pulses for 1 cycle. o_address keeps its last value; if the abort occurs in DATA, o_address is already updated.
- Read path:
  - On the first detected SCLK falling edge in DATA, i_rdata is loaded into the 8-bit output shift register.
  - Each subsequent falling edge shifts the register left.
  - o_miso = output shift[7].
  - o_miso is 0 in IDLE, CMD and HOLD.
  - Read data is returned in byte1 of the same frame. For a write frame, MOSI is the data and MISO returns the old register value.
- Reserved bit6 of byte0 is ignored.

## Timing
- Reset values: o_miso=0, o_write_en=0, o_address=0, o_data=0, o_frame_err=0. The FSM resets to IDLE with counters cleared. Reset mid-frame discards the frame with no write and no o_frame_err.
- Edge-detect latency: 3 i_clk cycles from a pin edge to internal detection.
- o_write_en rises in the cycle after the 16th rising edge is detected, i.e. 4 cycles after the pin edge. It lasts exactly 1 cycle. o_address and o_data are stable in that cycle and afterwards.
- o_frame_err rises in the cycle after the cs_n rising edge is detected.
- SCLK high and low phases must each be at least 4 i_clk cycles. Faster SCLK is unsupported.
- cs_n must be high for at least 4 i_clk cycles between frames.
- A cs_n falling edge and an SCLK edge detected in the same cycle: the frame start takes priority and the SCLK edge is ignored.

## Configuration
- SPI_AUTOINC_EN defined (burst mode):
  - HOLD is replaced by continued DATA.
  - Each further 8 bits form another data byte, at address o_address+1, wrapping 63 -> 0.
  - Write bursts pulse o_write_en once per byte.
  - Read bursts reload i_rdata at the first falling edge of each byte.
  - A partial trailing byte (1-7 bits) on cs_n rise is dropped and pulses o_frame_err. A cs_n rise on a byte boundary does not.
- SPI_AUTOINC_EN undefined: exactly one data byte per frame; extra bits are ignored in HOLD.

## Test plan
- Write frame 0x85,0xA5 -> one o_write_en pulse with o_address=0x05 and o_data=0xA5; no second pulse.
- Read frame 0x05,0x00 with i_rdata=0x3C -> MISO bits 0,0,1,1,1,1,0,0 during byte1; o_write_en stays 0.
- cs_n raised after 11 bits of a write -> no write, o_frame_err pulses once, o_data unchanged.
- 24-bit write frame 0xBF,0x11,0x22:
  - macro undefined -> single write to 0x3F=0x11.
  - macro defined -> writes 0x3F=0x11, then 0x00=0x22 (wrap).
- i_reset_n asserted after 12 bits, then released, then a full write 0x81,0x7E -> no write before reset, then address 0x01 = 0x7E.
- Back-to-back frames with the minimum 4-cycle cs_n high time -> both writes occur.
